// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: baud divider helper,
// default sync byte and the two FSM state encodings.
// Optional feature macro: UART_RX_CHECKSUM_EN adds the SUM parser state.
package uart_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Clock cycles per bit on the serial line.
    function automatic int pulse_width(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    typedef enum logic [1:0] {
        BIT_IDLE,
        BIT_START,
        BIT_DATA,
        BIT_STOP
    } rx_bit_state_t;

    typedef enum logic [2:0] {
        PKT_WAIT_SYNC,
        PKT_ADDR,
        PKT_D3,
        PKT_D2,
        PKT_D1,
`ifdef UART_RX_CHECKSUM_EN
        PKT_D0,
        PKT_SUM
`else
        PKT_D0
`endif
    } rx_pkt_state_t;

endpackage

// File: rtl/uart_rx_controller_if.sv
// Word bus toward the bulk RAM/register side: address, 32-bit data and a
// valid/ready handshake.
interface w_busif;
    logic [31:0] data;
    logic [7:0]  addr;
    logic        valid;
    logic        ready;

    modport master (output data, output addr, output valid, input ready);
    modport slave  (input data, input addr, input valid, output ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 bit receiver: two-flop synchroniser on the raw pin, start-bit glitch
// rejection at mid-bit, LSB-first data sampling and stop-bit check.
module uart_rx
    import uart_pkg::*;
#(
    parameter int UART_BAUD_RATE = 115200,
    parameter int CLK_FREQ       = 100_000_000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       uart_rxd,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       stop_err
);

    localparam int PULSE_WIDTH = pulse_width(CLK_FREQ, UART_BAUD_RATE);
    localparam int CNT_W       = $clog2(PULSE_WIDTH + 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(PULSE_WIDTH / 2 - 1);

    logic [1:0]       sync_reg;
    logic             prev_reg;
    rx_bit_state_t    state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;
    logic             byte_valid_reg;
    logic [7:0]       byte_data_reg;
    logic             stop_err_reg;
    logic             rxd_s;

    assign rxd_s      = sync_reg[1];
    assign byte_valid = byte_valid_reg;
    assign byte_data  = byte_data_reg;
    assign stop_err   = stop_err_reg;

    // Bring the asynchronous pin into the clk domain; idle line reads high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], uart_rxd};
        end
    end

    // Bit-level FSM; byte_valid and stop_err are single-cycle registered pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_reg       <= 1'b1;
            state_reg      <= BIT_IDLE;
            cnt_reg        <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            byte_valid_reg <= 1'b0;
            byte_data_reg  <= '0;
            stop_err_reg   <= 1'b0;
        end else begin
            prev_reg       <= rxd_s;
            byte_valid_reg <= 1'b0;
            stop_err_reg   <= 1'b0;
            case (state_reg)
                BIT_IDLE: begin
                    cnt_reg     <= '0;
                    bit_idx_reg <= '0;
                    if (prev_reg && !rxd_s) begin
                        state_reg <= BIT_START;
                    end
                end
                BIT_START: begin
                    if (cnt_reg == HALF_LAST) begin
                        cnt_reg <= '0;
                        // A line already back high at mid start bit was a glitch.
                        state_reg <= rxd_s ? BIT_IDLE : BIT_DATA;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                BIT_DATA: begin
                    if (cnt_reg == FULL_LAST) begin
                        cnt_reg   <= '0;
                        shift_reg <= {rxd_s, shift_reg[7:1]};
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= BIT_STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                BIT_STOP: begin
                    if (cnt_reg == FULL_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= BIT_IDLE;
                        if (rxd_s) begin
                            byte_valid_reg <= 1'b1;
                            byte_data_reg  <= shift_reg;
                        end else begin
                            stop_err_reg <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= BIT_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive controller: turns sync/addr/data[/sum] byte packets into
// words on a w_busif master port, with an inter-byte timeout.
// Optional feature macro: UART_RX_CHECKSUM_EN (7-byte packets with a
// trailing 8-bit wrap-around sum of addr and data bytes).
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int         UART_BAUD_RATE = 115200,
    parameter int         CLK_FREQ       = 100_000_000,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_BITS   = 20
) (
    input  logic   clk,
    input  logic   rstn,
    input  logic   uart_rxd,
    w_busif.master bulk_rx,
    output logic   frame_err,
    output logic   overrun
);

    localparam int PULSE_WIDTH = pulse_width(CLK_FREQ, UART_BAUD_RATE);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_BITS * PULSE_WIDTH - 1);

    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          stop_err;

    rx_pkt_state_t pkt_state_reg;
    logic [7:0]    pkt_addr_reg;
    logic [31:0]   pkt_data_reg;
    logic          done_reg;
    logic          sum_err_reg;
    logic          tmo_err_reg;
    logic [31:0]   tmo_cnt_reg;
`ifdef UART_RX_CHECKSUM_EN
    logic [7:0]    sum_reg;
`endif

    logic          valid_reg;
    logic [7:0]    out_addr_reg;
    logic [31:0]   out_data_reg;
    logic          overrun_reg;
    logic          frame_err_reg;

    uart_rx #(
        .UART_BAUD_RATE (UART_BAUD_RATE),
        .CLK_FREQ       (CLK_FREQ)
    ) u_rx (
        .clk        (clk),
        .rstn       (rstn),
        .uart_rxd   (uart_rxd),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .stop_err   (stop_err)
    );

    assign bulk_rx.valid = valid_reg;
    assign bulk_rx.addr  = out_addr_reg;
    assign bulk_rx.data  = out_data_reg;
    assign frame_err     = frame_err_reg;
    assign overrun       = overrun_reg;

    // Packet parser plus timeout; done_reg marks a complete, checked word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pkt_state_reg <= PKT_WAIT_SYNC;
            pkt_addr_reg  <= '0;
            pkt_data_reg  <= '0;
            done_reg      <= 1'b0;
            sum_err_reg   <= 1'b0;
            tmo_err_reg   <= 1'b0;
            tmo_cnt_reg   <= '0;
`ifdef UART_RX_CHECKSUM_EN
            sum_reg       <= '0;
`endif
        end else begin
            done_reg    <= 1'b0;
            sum_err_reg <= 1'b0;
            tmo_err_reg <= 1'b0;
            if (byte_valid) begin
                tmo_cnt_reg <= '0;
                case (pkt_state_reg)
                    PKT_WAIT_SYNC: begin
                        if (byte_data == SYNC_BYTE) begin
                            pkt_state_reg <= PKT_ADDR;
                        end
                    end
                    PKT_ADDR: begin
                        pkt_addr_reg  <= byte_data;
`ifdef UART_RX_CHECKSUM_EN
                        sum_reg       <= byte_data;
`endif
                        pkt_state_reg <= PKT_D3;
                    end
                    PKT_D3, PKT_D2, PKT_D1: begin
                        // Data arrives MSB first, so shift in from the bottom.
                        pkt_data_reg <= {pkt_data_reg[23:0], byte_data};
`ifdef UART_RX_CHECKSUM_EN
                        sum_reg      <= sum_reg + byte_data;
`endif
                        if (pkt_state_reg == PKT_D3) begin
                            pkt_state_reg <= PKT_D2;
                        end else if (pkt_state_reg == PKT_D2) begin
                            pkt_state_reg <= PKT_D1;
                        end else begin
                            pkt_state_reg <= PKT_D0;
                        end
                    end
                    PKT_D0: begin
                        pkt_data_reg  <= {pkt_data_reg[23:0], byte_data};
`ifdef UART_RX_CHECKSUM_EN
                        sum_reg       <= sum_reg + byte_data;
                        pkt_state_reg <= PKT_SUM;
`else
                        done_reg      <= 1'b1;
                        pkt_state_reg <= PKT_WAIT_SYNC;
`endif
                    end
`ifdef UART_RX_CHECKSUM_EN
                    PKT_SUM: begin
                        if (byte_data == sum_reg) begin
                            done_reg <= 1'b1;
                        end else begin
                            sum_err_reg <= 1'b1;
                        end
                        pkt_state_reg <= PKT_WAIT_SYNC;
                    end
`endif
                    default: pkt_state_reg <= PKT_WAIT_SYNC;
                endcase
            end else if (pkt_state_reg != PKT_WAIT_SYNC) begin
                // A stalled packet is abandoned so the next sync byte can be seen.
                if (tmo_cnt_reg == TMO_LAST) begin
                    tmo_cnt_reg   <= '0;
                    tmo_err_reg   <= 1'b1;
                    pkt_state_reg <= PKT_WAIT_SYNC;
                end else begin
                    tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
                end
            end else begin
                tmo_cnt_reg <= '0;
            end
        end
    end

    // Output holding register with valid/ready handshake and error pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_reg     <= 1'b0;
            out_addr_reg  <= '0;
            out_data_reg  <= '0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            overrun_reg   <= 1'b0;
            frame_err_reg <= stop_err | sum_err_reg | tmo_err_reg;
            if (done_reg) begin
                // A word accepted this very cycle frees the slot for the new one.
                if (valid_reg && !bulk_rx.ready) begin
                    overrun_reg <= 1'b1;
                end else begin
                    valid_reg    <= 1'b1;
                    out_addr_reg <= pkt_addr_reg;
                    out_data_reg <= pkt_data_reg;
                end
            end else if (valid_reg && bulk_rx.ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

endmodule
